// File: rtl/orv_rvc_realign_if.sv
// Fetch-side and decode-side handshake bundle for the RVC realigner.
// Both channels are valid/ready: a transfer happens on a clock edge where valid and
// ready are both high; once valid is raised, the payload stays stable until that transfer.
interface orv_rvc_realign_if #(
  parameter int PC_WIDTH = 64
);
  logic                flush;
  logic [PC_WIDTH-1:0] flush_pc;
  logic                fetch_valid;
  logic                fetch_ready;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [31:0]         fetch_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [31:0]         inst;
  logic [PC_WIDTH-1:0] inst_pc;
  logic                inst_is_rvc;
  logic                inst_illegal;

  modport master (
    output flush, flush_pc, fetch_valid, fetch_pc, fetch_data, inst_ready,
    input  fetch_ready, inst_valid, inst, inst_pc, inst_is_rvc, inst_illegal
  );

  modport slave (
    input  flush, flush_pc, fetch_valid, fetch_pc, fetch_data, inst_ready,
    output fetch_ready, inst_valid, inst, inst_pc, inst_is_rvc, inst_illegal
  );
endinterface

// File: rtl/orv_rvc_realign.sv
// Realigns 32-bit fetch words into whole instructions and expands RVC halfwords to RV64I,
// so decode only ever sees uncompressed encodings.
module orv_rvc_realign #(
  parameter int PC_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rstn,
  orv_rvc_realign_if.slave    bus,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_SKIP  = 2'd2;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_REG32 = 7'b0111011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  // Returns {illegal, instruction}; illegal encodings yield the zero-extended halfword.
  function automatic logic [32:0] rvc_expand(input logic [15:0] h);
    logic [31:0] o;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [5:0]  shamt;
    logic [11:0] imm6, a4spn, a16sp, lw_off, ld_off, lwsp_off, ldsp_off, swsp_off, sdsp_off;
    logic [19:0] lui20;
    logic [20:0] jimm;
    logic [12:0] bimm;
    rd       = h[11:7];
    rs2      = h[6:2];
    rdp      = {2'b01, h[4:2]};
    rs1p     = {2'b01, h[9:7]};
    shamt    = {h[12], h[6:2]};
    imm6     = {{6{h[12]}}, h[12], h[6:2]};
    a4spn    = {2'b00, h[10:7], h[12:11], h[5], h[6], 2'b00};
    a16sp    = {{3{h[12]}}, h[4:3], h[5], h[2], h[6], 4'b0000};
    lw_off   = {5'b00000, h[5], h[12:10], h[6], 2'b00};
    ld_off   = {4'b0000, h[6:5], h[12:10], 3'b000};
    lwsp_off = {4'b0000, h[3:2], h[12], h[6:4], 2'b00};
    ldsp_off = {3'b000, h[4:2], h[12], h[6:5], 3'b000};
    swsp_off = {4'b0000, h[8:7], h[12:9], 2'b00};
    sdsp_off = {3'b000, h[9:7], h[12:10], 3'b000};
    lui20    = {{15{h[12]}}, h[6:2]};
    jimm     = {{10{h[12]}}, h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3], 1'b0};
    bimm     = {{5{h[12]}}, h[6:5], h[2], h[11:10], h[4:3], 1'b0};
    o   = 32'h0;
    ill = 1'b0;
    case ({h[1:0], h[15:13]})
      5'b00_000: begin
        if (a4spn == 12'h0) ill = 1'b1;
        else o = {a4spn, 5'd2, 3'b000, rdp, OP_IMM};
      end
      5'b00_010: o = {lw_off, rs1p, 3'b010, rdp, OP_LOAD};
      5'b00_011: o = {ld_off, rs1p, 3'b011, rdp, OP_LOAD};
      5'b00_110: o = {lw_off[11:5], rdp, rs1p, 3'b010, lw_off[4:0], OP_STORE};
      5'b00_111: o = {ld_off[11:5], rdp, rs1p, 3'b011, ld_off[4:0], OP_STORE};
      5'b01_000: o = {imm6, rd, 3'b000, rd, OP_IMM};
      5'b01_001: begin
        if (rd == 5'd0) ill = 1'b1;
        else o = {imm6, rd, 3'b000, rd, OP_IMM32};
      end
      5'b01_010: o = {imm6, 5'd0, 3'b000, rd, OP_IMM};
      5'b01_011: begin
        if (rd == 5'd2) begin
          if (a16sp == 12'h0) ill = 1'b1;
          else o = {a16sp, 5'd2, 3'b000, 5'd2, OP_IMM};
        end else begin
          if (shamt == 6'd0) ill = 1'b1;
          else o = {lui20, rd, OP_LUI};
        end
      end
      5'b01_100: begin
        case (h[11:10])
          2'b00: o = {6'b000000, shamt, rs1p, 3'b101, rs1p, OP_IMM};
          2'b01: o = {6'b010000, shamt, rs1p, 3'b101, rs1p, OP_IMM};
          2'b10: o = {imm6, rs1p, 3'b111, rs1p, OP_IMM};
          default: begin
            case ({h[12], h[6:5]})
              3'b000:  o = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
              3'b001:  o = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG};
              3'b010:  o = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG};
              3'b011:  o = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG};
              3'b100:  o = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG32};
              3'b101:  o = {7'b0000000, rdp, rs1p, 3'b000, rs1p, OP_REG32};
              default: ill = 1'b1;
            endcase
          end
        endcase
      end
      5'b01_101: o = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, OP_JAL};
      5'b01_110: o = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b000, bimm[4:1], bimm[11], OP_BR};
      5'b01_111: o = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b001, bimm[4:1], bimm[11], OP_BR};
      5'b10_000: o = {6'b000000, shamt, rd, 3'b001, rd, OP_IMM};
      5'b10_010: begin
        if (rd == 5'd0) ill = 1'b1;
        else o = {lwsp_off, 5'd2, 3'b010, rd, OP_LOAD};
      end
      5'b10_011: begin
        if (rd == 5'd0) ill = 1'b1;
        else o = {ldsp_off, 5'd2, 3'b011, rd, OP_LOAD};
      end
      5'b10_100: begin
        if (!h[12]) begin
          if (rs2 != 5'd0)     o = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_REG};
          else if (rd == 5'd0) ill = 1'b1;
          else                 o = {12'h000, rd, 3'b000, 5'd0, OP_JALR};
        end else begin
          if (rs2 != 5'd0)     o = {7'b0000000, rs2, rd, 3'b000, rd, OP_REG};
          else if (rd == 5'd0) o = 32'h0010_0073;
          else                 o = {12'h000, rd, 3'b000, 5'd1, OP_JALR};
        end
      end
      5'b10_110: o = {swsp_off[11:5], rs2, 5'd2, 3'b010, swsp_off[4:0], OP_STORE};
      5'b10_111: o = {sdsp_off[11:5], rs2, 5'd2, 3'b011, sdsp_off[4:0], OP_STORE};
      default:   ill = 1'b1;
    endcase
    if (ill) o = {16'h0000, h};
    return {ill, o};
  endfunction

  logic [1:0]          state;
  logic [15:0]         hld;
  logic [PC_WIDTH-1:0] hld_pc;

  logic                out_valid;
  logic [31:0]         out_inst;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_rvc;
  logic                out_ill;

  logic                can_load;
  logic                hld_is_32;
  logic                fetch_ok;
  logic                fetch_take;
  logic                emit;
  logic                emit_rvc;
  logic [15:0]         emit_half;
  logic [31:0]         emit_native;
  logic [PC_WIDTH-1:0] emit_pc;
  logic [32:0]         exp_res;
  logic [PC_WIDTH-1:0] next_hld_pc;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{bus.flush_pc[PC_WIDTH-1:2], bus.flush_pc[0]};
  assign next_hld_pc    = bus.fetch_pc + PC_WIDTH'(2);

  always_comb begin
    can_load    = !out_valid || bus.inst_ready;
    hld_is_32   = (hld[1:0] == 2'b11);
    fetch_ok    = rstn && !bus.flush && can_load && ((state != ST_HOLD) || hld_is_32);
    fetch_take  = fetch_ok && bus.fetch_valid;
    emit        = 1'b0;
    emit_rvc    = 1'b0;
    emit_half   = hld;
    emit_native = bus.fetch_data;
    emit_pc     = bus.fetch_pc;
    case (state)
      ST_EMPTY: begin
        if (fetch_take) begin
          emit      = 1'b1;
          emit_rvc  = (bus.fetch_data[1:0] != 2'b11);
          emit_half = bus.fetch_data[15:0];
        end
      end
      ST_HOLD: begin
        emit_pc = hld_pc;
        // A held compressed halfword is self-contained and needs no fetch word.
        if (!hld_is_32) begin
          emit     = rstn && !bus.flush && can_load;
          emit_rvc = 1'b1;
        end else if (fetch_take) begin
          emit        = 1'b1;
          emit_native = {bus.fetch_data[15:0], hld};
        end
      end
      default: ;
    endcase
    exp_res = rvc_expand(emit_half);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_EMPTY;
      hld       <= 16'h0;
      hld_pc    <= '0;
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_pc    <= '0;
      out_rvc   <= 1'b0;
      out_ill   <= 1'b0;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
      state     <= bus.flush_pc[1] ? ST_SKIP : ST_EMPTY;
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        out_inst  <= emit_rvc ? exp_res[31:0] : emit_native;
        out_pc    <= emit_pc;
        out_rvc   <= emit_rvc;
        out_ill   <= emit_rvc && exp_res[32];
      end else if (bus.inst_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_EMPTY: begin
          if (fetch_take && (bus.fetch_data[1:0] != 2'b11)) begin
            hld    <= bus.fetch_data[31:16];
            hld_pc <= next_hld_pc;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!hld_is_32) begin
            if (emit) state <= ST_EMPTY;
          end else if (fetch_take) begin
            hld    <= bus.fetch_data[31:16];
            hld_pc <= next_hld_pc;
          end
        end
        ST_SKIP: begin
          if (fetch_take) begin
            hld    <= bus.fetch_data[31:16];
            hld_pc <= next_hld_pc;
            state  <= ST_HOLD;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.fetch_ready  = fetch_ok;
  assign bus.inst_valid   = out_valid;
  assign bus.inst         = out_inst;
  assign bus.inst_pc      = out_pc;
  assign bus.inst_is_rvc  = out_rvc;
  assign bus.inst_illegal = out_ill;
  assign dbg_state        = state;

endmodule
